array_mul_arbiter: RTL
======================

// Module: array_mul_arbiter
// PURPOSE
//  Round-robin scheduler that shares one n_bit_array_mul instance between R requesters.
//  Arbitrates requests and sequences the multiplier's shared data_in bus through the
//  load_a and load_b cycles. Waits out the multiplier latency, captures the product and
//  returns it with the requester ID over a valid/ready response port.
//  Sits between client blocks and the multiplier; the only driver of its data_in/load_a/load_b.
// PARAMETERS
//  N        8  operand width; must match the multiplier's N
//  R        4  number of requesters (>=2); ID width IDW = $clog2(R)
//  MUL_LAT  2  cycles from the end of the load_b cycle to a valid mul_product (>=2)
// PORTS
//  clk          in   1      clock; all state on posedge
//  clr_n        in   1      asynchronous active-low reset
//  req_valid    in   R      per-requester request; held high until req_ready is seen
//  req_a        in   R*N    operand A; requester i uses bits [N*i+:N]
//  req_b        in   R*N    operand B; requester i uses bits [N*i+:N]
//  req_ready    out  R      one-hot, 1-cycle grant/accept pulse
//  rsp_valid    out  1      result available
//  rsp_id       out  IDW    index of the requester that owns the result
//  rsp_product  out  2N     A*B, unsigned
//  rsp_ready    in   1      consumer accepts the result
//  busy         out  1      high in every state except IDLE
//  mul_data_in  out  N      to multiplier data_in
//  mul_load_a   out  1      to multiplier load_a
//  mul_load_b   out  1      to multiplier load_b
//  mul_product  in   2N     from multiplier product
// BEHAVIOUR
//  Reset (clr_n=0, async):
//   - all outputs 0, FSM->IDLE, rr_ptr=0, wait counter 0, op/id latches 0.
//   - Applies mid-operation: the in-flight op is discarded, no response is produced,
//     and the multiplier registers are left as they are.
//  FSM: IDLE -> LOAD_A -> LOAD_B -> WAIT -> RESP -> IDLE
//   IDLE (cycle G):
//    - If any req_valid bit is set, grant the first set bit searching from rr_ptr upward,
//      wrapping at R.
//    - req_ready[g]=1 for this cycle only; latch req_a[g], req_b[g] and g on the edge.
//    - No request: stay in IDLE.
//   LOAD_A (G+1): mul_data_in=op_a, mul_load_a=1.
//   LOAD_B (G+2): mul_data_in=op_b, mul_load_b=1; wait counter loaded with MUL_LAT.
//   WAIT (G+3 .. G+2+MUL_LAT):
//    - Counter decrements each cycle.
//    - On the edge ending the last WAIT cycle: rsp_product<=mul_product,
//      rsp_id<=latched id, rsp_valid<=1, go to RESP.
//   RESP:
//    - rsp_valid, rsp_id and rsp_product hold stable until rsp_ready=1.
//    - On the handshake edge: rsp_valid<=0, rr_ptr<=(id+1) mod R, go to IDLE.
//  Latency and throughput:
//   - rsp_valid first high in cycle G+3+MUL_LAT (G+5 at default).
//   - Minimum issue interval is 4+MUL_LAT cycles (next grant in the cycle after the handshake).
//  Outside LOAD_A/LOAD_B: mul_data_in=0 and both load strobes are 0; load_a and load_b
//   are never high in the same cycle.
//  Arbitration:
//   - At most one req_ready bit high per cycle.
//   - A requester whose req_valid stays high is granted within R grants (no starvation).
//   - req_valid changes outside IDLE are ignored; a bit dropped before its grant is
//     never granted.
//  Arithmetic: unsigned; the 2N-bit product never overflows.
//  rsp_ready high in the first RESP cycle gives exactly one RESP cycle.
// TESTING
//  1. N=8,R=4: req 2 only, A=13,B=11 -> req_ready=4'b0100 at G; mul_load_a at G+1,
//     mul_load_b at G+2; rsp_valid at G+5, rsp_id=2, rsp_product=16'h008F.
//  2. All 4 req_valid held high, rsp_ready=1 -> grant order 0,1,2,3,0; each product correct;
//     grants spaced 6 cycles apart.
//  3. A=255,B=255 -> 16'hFE01; A=0,B=200 -> 0; A=1,B=173 -> 173.
//  4. rsp_ready held low 10 cycles -> rsp_valid/id/product stable; no new req_ready or load
//     strobes; the next grant comes the cycle after rsp_ready rises.
//  5. clr_n pulsed low during WAIT -> all outputs 0 immediately (async); no response for the
//     aborted op; the next request is granted from rr_ptr=0.
//  6. Bus check every cycle: load_a&load_b never 1; mul_data_in==0 whenever no load strobe.

Source files
------------

// File: rtl/array_mul_arbiter_if.sv
// rtl/array_mul_arbiter_if.sv - requester, response and multiplier bus bundle for array_mul_arbiter
interface array_mul_arbiter_if #(
    parameter int N = 8,
    parameter int R = 4
);
    localparam int IDW = (R > 1) ? $clog2(R) : 1;

    logic [R-1:0]     req_valid;
    logic [R*N-1:0]   req_a;
    logic [R*N-1:0]   req_b;
    logic [R-1:0]     req_ready;
    logic             rsp_valid;
    logic [IDW-1:0]   rsp_id;
    logic [2*N-1:0]   rsp_product;
    logic             rsp_ready;
    logic             busy;
    logic [N-1:0]     mul_data_in;
    logic             mul_load_a;
    logic             mul_load_b;
    logic [2*N-1:0]   mul_product;

    // arbiter side
    modport slave (
        input  req_valid, req_a, req_b, rsp_ready, mul_product,
        output req_ready, rsp_valid, rsp_id, rsp_product, busy,
               mul_data_in, mul_load_a, mul_load_b
    );

    // clients, response consumer and multiplier side
    modport master (
        output req_valid, req_a, req_b, rsp_ready, mul_product,
        input  req_ready, rsp_valid, rsp_id, rsp_product, busy,
               mul_data_in, mul_load_a, mul_load_b
    );
endinterface

// File: rtl/array_mul_arbiter.sv
// rtl/array_mul_arbiter.sv - round-robin scheduler sharing one array multiplier between R requesters
module array_mul_arbiter #(
    parameter int N       = 8,
    parameter int R       = 4,
    parameter int MUL_LAT = 2
) (
    input  logic               clk,
    input  logic               clr_n,
    array_mul_arbiter_if.slave bus
);
    localparam int IDW = (R > 1) ? $clog2(R) : 1;
    localparam int CW  = $clog2(MUL_LAT + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        WAIT   = 3'd3,
        RESP   = 3'd4
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   op_id;
    logic [N-1:0]     op_a;
    logic [N-1:0]     op_b;
    logic [CW-1:0]    wait_cnt;
    logic             rsp_valid_q;
    logic [IDW-1:0]   rsp_id_q;
    logic [2*N-1:0]   rsp_product_q;

    logic             grant_any;
    logic [IDW-1:0]   grant_id;
    logic [IDW-1:0]   scan_idx;
    logic [R-1:0]     grant_onehot;
    logic [N-1:0]     sel_a;
    logic [N-1:0]     sel_b;
    logic             grant_fire;
    logic             wait_last;

    // first pending request at or above rr_ptr, wrapping at R; the lowest offset wins
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        scan_idx  = '0;
        for (int k = R - 1; k >= 0; k--) begin
            scan_idx = IDW'((int'(rr_ptr) + k) % R);
            if (bus.req_valid[scan_idx]) begin
                grant_any = 1'b1;
                grant_id  = scan_idx;
            end
        end
    end

    // operand mux for the granted requester and its one-hot accept vector
    always_comb begin
        sel_a        = '0;
        sel_b        = '0;
        grant_onehot = '0;
        for (int k = 0; k < R; k++) begin
            if (grant_id == IDW'(k)) begin
                sel_a           = bus.req_a[k*N +: N];
                sel_b           = bus.req_b[k*N +: N];
                grant_onehot[k] = 1'b1;
            end
        end
    end

    // a grant only fires out of reset so req_ready is 0 while clr_n is held low
    assign grant_fire = (state == IDLE) && grant_any && clr_n;
    assign wait_last  = (wait_cnt == CW'(1));

    // state register
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next state and the multiplier bus / accept strobes
    always_comb begin
        state_nxt       = state;
        bus.req_ready   = '0;
        bus.mul_data_in = '0;
        bus.mul_load_a  = 1'b0;
        bus.mul_load_b  = 1'b0;
        case (state)
            IDLE: begin
                if (grant_fire) begin
                    bus.req_ready = grant_onehot;
                    state_nxt     = LOAD_A;
                end
            end
            LOAD_A: begin
                bus.mul_data_in = op_a;
                bus.mul_load_a  = 1'b1;
                state_nxt       = LOAD_B;
            end
            LOAD_B: begin
                bus.mul_data_in = op_b;
                bus.mul_load_b  = 1'b1;
                state_nxt       = WAIT;
            end
            WAIT: begin
                if (wait_last) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // operand latch, latency counter, response register and round-robin pointer
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            rr_ptr        <= '0;
            op_id         <= '0;
            op_a          <= '0;
            op_b          <= '0;
            wait_cnt      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= '0;
            rsp_product_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_fire) begin
                        op_a  <= sel_a;
                        op_b  <= sel_b;
                        op_id <= grant_id;
                    end
                end
                LOAD_B: begin
                    wait_cnt <= CW'(MUL_LAT);
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - 1'b1;
                    if (wait_last) begin
                        rsp_product_q <= bus.mul_product;
                        rsp_id_q      <= op_id;
                        rsp_valid_q   <= 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        if (op_id == IDW'(R - 1)) begin
                            rr_ptr <= '0;
                        end else begin
                            rr_ptr <= op_id + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_id      = rsp_id_q;
    assign bus.rsp_product = rsp_product_q;
    assign bus.busy        = (state != IDLE);
endmodule
